// File: rtl/uart_pattern_gen.sv
// Test-pattern word source for the UART transmitter: counter, fixed, LFSR and walking-one bursts.
// Latency: first word is offered the cycle after start; next word the cycle after each accept (+GAP_CYCLES idle).
// Backpressure: a word is held stable on data/data_valid while busy is high; it is consumed only when data_valid & ~busy.
module uart_pattern_gen #(
  parameter int DATA_W     = 8,
  parameter int BURST_LEN  = 16,
  parameter int GAP_CYCLES = 8,
  parameter int LFSR_SEED  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              enable,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fixed_val,
  input  logic              busy,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              burst_done,
  output logic              active,
  output logic [15:0]       sent_count
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  // Gap counter only needs to reach GAP_CYCLES-1; keep at least one bit so
  // the GAP_CYCLES=0 build still elaborates (GAP is unreachable there).
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]     GAP_LAST    = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [15:0]       BURST_LEN_W = 16'(BURST_LEN);
  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  localparam logic [DATA_W-1:0] SEED        = (LFSR_SEED == 0) ? DATA_W'(1) : DATA_W'(LFSR_SEED);
  // Feedback taps: 8-bit uses bits 7,5,4,3; 16-bit uses bits 15,14,12,3.
  localparam logic [DATA_W-1:0] TAPS        = (DATA_W == 16) ? DATA_W'(16'hD008) : DATA_W'(8'hB8);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_data;
  logic [15:0]       r_sent;
  logic [GW-1:0]     r_gap;

  logic              w_accept;
  logic              w_start;
  logic [15:0]       w_sent_inc;
  logic [DATA_W-1:0] w_next_word;
  logic [DATA_W-1:0] w_first_word;

  assign w_accept   = (r_state == S_SEND) && !busy;
  assign w_start    = (r_state == S_IDLE) && start && enable;
  assign w_sent_inc = (r_sent == 16'hFFFF) ? r_sent : r_sent + 16'd1;
  assign data       = r_data;
  assign sent_count = r_sent;

  // Successor of the current word under the mode latched for this burst.
  always_comb begin
    w_next_word = r_data;
    case (r_mode)
      2'd0:    w_next_word = r_data + DATA_W'(1);
      2'd1:    w_next_word = r_data;
      2'd2:    w_next_word = {r_data[DATA_W-2:0], ^(r_data & TAPS)};
      default: w_next_word = {r_data[DATA_W-2:0], r_data[DATA_W-1]};
    endcase
  end

  // First word of a burst, taken from the live mode/fixed_val at start.
  always_comb begin
    w_first_word = '0;
    case (mode)
      2'd0:    w_first_word = '0;
      2'd1:    w_first_word = fixed_val;
      2'd2:    w_first_word = SEED;
      default: w_first_word = DATA_W'(1);
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; enable low aborts from any busy state.
  always_comb begin
    w_state_nxt = r_state;
    data_valid  = 1'b0;
    burst_done  = 1'b0;
    active      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        data_valid = 1'b1;
        active     = 1'b1;
        if (!enable) begin
          w_state_nxt = S_IDLE;
        end else if (w_accept) begin
          if ((BURST_LEN != 0) && (w_sent_inc == BURST_LEN_W)) w_state_nxt = S_DONE;
          else if (GAP_CYCLES == 0)                            w_state_nxt = S_SEND;
          else                                                 w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        active = 1'b1;
        if (!enable)                w_state_nxt = S_IDLE;
        else if (r_gap == GAP_LAST) w_state_nxt = S_SEND;
      end
      default: begin
        active      = 1'b1;
        burst_done  = enable;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: burst setup at start, word advance and count on every accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mode <= 2'd0;
      r_data <= '0;
      r_sent <= 16'd0;
      r_gap  <= '0;
    end else begin
      if (w_start) begin
        r_mode <= mode;
        r_data <= w_first_word;
        r_sent <= 16'd0;
      end else if (w_accept) begin
        r_data <= w_next_word;
        r_sent <= w_sent_inc;
      end
      r_gap <= (r_state == S_GAP) ? r_gap + GW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_uart_pattern_gen.sv
// Directed bench for uart_pattern_gen: four instances with different burst/gap/width settings share one stimulus.
// Latency: checks are sampled 1 ns after each rising edge, inputs are driven at the same point.
// Backpressure: busy is driven directly to hold words and observe stalls.
module tb_uart_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, enable, start, busy;
  logic [1:0]  mode;
  logic [7:0]  fixed_val;
  logic [15:0] fixed_val16;
  assign fixed_val16 = {8'h00, fixed_val};

  logic [7:0]  a_data, b_data, c_data;
  logic [15:0] d_data;
  logic        a_dv, a_done, a_active;
  logic        b_dv, b_done, b_active;
  logic        c_dv, c_done, c_active;
  logic        d_dv, d_done, d_active;
  logic [15:0] a_sent, b_sent, c_sent, d_sent;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  c_exp [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
  logic [15:0] d_exp [6] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0011, 16'h0022};

  uart_pattern_gen #(.DATA_W(8), .BURST_LEN(4), .GAP_CYCLES(2), .LFSR_SEED(1)) u_a (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start), .mode(mode),
    .fixed_val(fixed_val), .busy(busy), .data(a_data), .data_valid(a_dv),
    .burst_done(a_done), .active(a_active), .sent_count(a_sent));

  uart_pattern_gen #(.DATA_W(8), .BURST_LEN(0), .GAP_CYCLES(0), .LFSR_SEED(1)) u_b (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start), .mode(mode),
    .fixed_val(fixed_val), .busy(busy), .data(b_data), .data_valid(b_dv),
    .burst_done(b_done), .active(b_active), .sent_count(b_sent));

  uart_pattern_gen #(.DATA_W(8), .BURST_LEN(5), .GAP_CYCLES(0), .LFSR_SEED(0)) u_c (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start), .mode(mode),
    .fixed_val(fixed_val), .busy(busy), .data(c_data), .data_valid(c_dv),
    .burst_done(c_done), .active(c_active), .sent_count(c_sent));

  uart_pattern_gen #(.DATA_W(16), .BURST_LEN(0), .GAP_CYCLES(0), .LFSR_SEED(1)) u_d (
    .clk(clk), .resetn(resetn), .enable(enable), .start(start), .mode(mode),
    .fixed_val(fixed_val16), .busy(busy), .data(d_data), .data_valid(d_dv),
    .burst_done(d_done), .active(d_active), .sent_count(d_sent));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b0;
    start  = 1'b0;
    busy   = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic kick(input logic [1:0] m);
    mode   = m;
    enable = 1'b1;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    mode      = 2'd0;
    fixed_val = 8'h00;

    // Reset state
    do_reset();
    check("rst_data",   a_data,   0);
    check("rst_dv",     a_dv,     0);
    check("rst_done",   a_done,   0);
    check("rst_active", a_active, 0);
    check("rst_sent",   a_sent,   0);
    check("rst_d_dv",   d_dv,     0);

    // Counter burst of 4 with 2-cycle gaps: words at k=0,3,6,9, done at k=10
    kick(2'd0);
    for (int k = 0; k < 12; k++) begin
      check("cnt_dv",     a_dv,     ((k % 3) == 0) && (k <= 9));
      check("cnt_done",   a_done,   k == 10);
      check("cnt_active", a_active, k <= 10);
      if (((k % 3) == 0) && (k <= 9)) check("cnt_data", a_data, k / 3);
      step();
    end
    check("cnt_sent",      a_sent, 4);
    check("cnt_data_hold", a_data, 8'h04);

    // LFSR back-to-back, 8-bit burst of 5 (zero seed) and 16-bit continuous
    do_reset();
    kick(2'd2);
    for (int k = 0; k < 7; k++) begin
      if (k < 5) begin
        check("lfsr8_dv",   c_dv,   1);
        check("lfsr8_data", c_data, c_exp[k]);
      end
      if (k == 5) begin
        check("lfsr8_done", c_done, 1);
        check("lfsr8_dv_done", c_dv, 0);
      end
      if (k < 6) begin
        check("lfsr16_dv",   d_dv,   1);
        check("lfsr16_data", d_data, d_exp[k]);
      end
      step();
    end
    check("lfsr8_active", c_active, 0);
    check("lfsr8_sent",   c_sent,   5);
    check("lfsr16_active", d_active, 1);
    check("lfsr16_no_done", d_done, 0);
    check("lfsr16_sent",  d_sent,   7);

    // Fixed word held under busy for 20 cycles, then one accept
    do_reset();
    fixed_val = 8'h5A;
    busy = 1'b1;
    kick(2'd1);
    for (int k = 0; k < 20; k++) begin
      check("stall_dv",   a_dv,   1);
      check("stall_data", a_data, 8'h5A);
      check("stall_sent", a_sent, 0);
      step();
    end
    busy = 1'b0;
    check("stall_dv_rel", a_dv, 1);
    step();
    check("stall_sent_after", a_sent, 1);
    check("stall_dv_gap",     a_dv,   0);
    check("stall_data_after", a_data, 8'h5A);

    // Walking-one over 9 words, MSB wraps to bit 0
    do_reset();
    kick(2'd3);
    for (int k = 0; k < 9; k++) begin
      logic [7:0] w;
      w = 8'(1 << (k % 8));
      check("walk_dv",   b_dv,   1);
      check("walk_data", b_data, w);
      check("walk_done", b_done, 0);
      step();
    end
    check("walk_sent",   b_sent,   9);
    check("walk_active", b_active, 1);

    // Continuous counter wrap after 256 accepts
    do_reset();
    kick(2'd0);
    for (int k = 0; k < 255; k++) step();
    check("wrap_ff",   b_data, 8'hFF);
    check("wrap_sent255", b_sent, 255);
    step();
    check("wrap_00",   b_data, 8'h00);
    check("wrap_sent", b_sent, 256);
    check("wrap_dv",   b_dv,   1);

    // Abort in GAP
    do_reset();
    kick(2'd0);
    step();
    check("abort_gap_dv",   a_dv,   0);
    check("abort_gap_sent", a_sent, 1);
    enable = 1'b0;
    step();
    check("abort_active", a_active, 0);
    check("abort_dv",     a_dv,     0);
    check("abort_done",   a_done,   0);
    check("abort_sent",   a_sent,   1);
    check("abort_data",   a_data,   8'h01);
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_no_done", a_done, 0);
      check("abort_hold",    a_sent, 1);
    end

    // Reset in SEND mid-burst
    do_reset();
    fixed_val = 8'hA5;
    kick(2'd1);
    step();
    step();
    step();
    check("midrst_pre_dv",   a_dv,   1);
    check("midrst_pre_sent", a_sent, 1);
    check("midrst_pre_data", a_data, 8'hA5);
    resetn = 1'b0;
    step();
    check("midrst_data",   a_data,   0);
    check("midrst_dv",     a_dv,     0);
    check("midrst_active", a_active, 0);
    check("midrst_sent",   a_sent,   0);
    check("midrst_done",   a_done,   0);
    resetn = 1'b1;

    // start while active is ignored (pulsed in GAP at k=1 and in SEND at k=3)
    do_reset();
    kick(2'd0);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_sent", a_sent, 2);
    check("restart_data", a_data, 8'h02);
    for (int k = 0; k < 6; k++) step();
    check("restart_done", a_done, 1);
    step();
    check("restart_final_sent", a_sent,   4);
    check("restart_active",     a_active, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_pattern_gen.md
Name: uart_pattern_gen

Overview:
- Parametrised test-pattern source that feeds the UART transmitter on the ULX3S.
- Generates bursts of words in four modes: counter, fixed, LFSR and walking-one.
- Uses a valid/busy handshake, a configurable inter-word gap and a configurable burst length.
- Reports progress through a sent-word counter and a one-cycle burst_done strobe.

Parameters:
- DATA_W, 8, word width; legal values are 8 or 16 only.
- BURST_LEN, 16, words per burst; 0 means continuous until enable is deasserted.
- GAP_CYCLES, 8, idle cycles inserted after each accepted word; 0 is legal.
- LFSR_SEED, 1, initial LFSR value; a seed of 0 is replaced by 1.

Ports:
- clk  input  1  system clock
- resetn  input  1  synchronous, active-low reset
- enable  input  1  run permission; low aborts any burst
- start  input  1  single-cycle request to begin a burst
- mode  input  2  pattern select: 0=counter, 1=fixed, 2=LFSR, 3=walking-one
- fixed_val  input  DATA_W  word used in fixed mode
- busy  input  1  transmitter busy
- data  output  DATA_W  current word
- data_valid  output  1  data is offered to the transmitter
- burst_done  output  1  one-cycle pulse when a burst completes
- active  output  1  burst in progress
- sent_count  output  16  words accepted in the current or last burst

Behaviour:
- Reset (resetn low at a clk edge):
  - state=IDLE.
  - data=0, data_valid=0, burst_done=0, active=0, sent_count=0.
  - Gap counter and LFSR state cleared.
  - Reset overrides every state, including mid-burst.
- Accept rule: accept = data_valid & ~busy, in the same cycle. The transmitter asserts busy the cycle after an accept.
- Data stability: data is stable while data_valid=1 and changes only on the cycle after an accept.
- States: IDLE, SEND, GAP, DONE. active=1 in SEND, GAP and DONE.
- IDLE:
  - start & enable moves to SEND on the next cycle.
  - mode and fixed_val are latched at that point and held for the whole burst.
  - sent_count is cleared to 0.
  - data is loaded with the first word: counter 0, fixed fixed_val, LFSR LFSR_SEED (1 if the seed is 0), walking-one 1.
  - start while not IDLE is ignored.
- SEND: data_valid=1. On accept:
  - sent_count increments, saturating at 16'hFFFF.
  - data takes the next pattern value.
  - If BURST_LEN!=0 and the new sent_count==BURST_LEN, go to DONE.
  - Else if GAP_CYCLES==0, stay in SEND; data_valid stays high with the new word.
  - Else go to GAP with the gap counter at 0.
- GAP:
  - data_valid=0.
  - Go to SEND when the gap counter reaches GAP_CYCLES-1.
  - Result: an accept at cycle t gives data_valid low for t+1..t+GAP_CYCLES and high at t+GAP_CYCLES+1.
- DONE: burst_done=1 for exactly one cycle, data_valid=0, then go to IDLE.
- Abort:
  - enable low in SEND, GAP or DONE moves to IDLE on the next cycle.
  - data_valid and active are low from that cycle on; no burst_done.
  - An accept in the same cycle still counts in sent_count.
  - sent_count holds its value after an abort.
- Next-value rules (all arithmetic modulo 2^DATA_W):
  - Counter: data+1, wrapping from all-ones to 0.
  - Fixed: unchanged.
  - Walking-one: rotate left; MSB wraps to bit 0.
  - LFSR: Fibonacci shift-left, next={d[W-2:0], fb}.
    - W=8: fb=d7^d5^d4^d3.
    - W=16: fb=d15^d14^d12^d3.
- After DONE or abort, data holds its last value; data_valid=0.

Test Plan:
- DATA_W=8, BURST_LEN=4, GAP_CYCLES=2, mode=0, busy=0, start pulse:
  - data 00,01,02,03 accepted.
  - data_valid is high one cycle per word with 2-cycle gaps.
  - burst_done pulses once; sent_count=4; active falls.
- mode=2, LFSR_SEED=1, BURST_LEN=5, GAP_CYCLES=0: words are 01,02,04,08,11, offered back-to-back.
- Busy stall, mode=1, fixed_val=8'h5A: busy held high for 20 cycles during SEND; data_valid stays 1 with data=5A and no accept; sent_count increments once, after busy drops.
- Walking-one and counter wrap:
  - mode=3, BURST_LEN=9: 01,02,04,...,80,01.
  - mode=0, BURST_LEN=0: after 256 accepts data returns to 00 and sent_count=256.
- Abort and reset mid-burst:
  - enable dropped in GAP gives IDLE next cycle, no burst_done, sent_count held.
  - resetn low in SEND clears all outputs to 0 next cycle.
- start asserted while active is ignored: sent_count is not cleared and the burst length is unchanged.
